// File: rtl/dsp_file_arbiter.sv
// rtl/dsp_file_arbiter.sv - round-robin arbiter sharing one DSP file-store port among four engines
module dsp_file_arbiter #(
    parameter int dw      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [31:0]     req_file_num,
    input  logic [3:0]      req_file_read,
    input  logic [3:0]      req_file_write,
    input  logic [4*dw-1:0] req_file_write_data,
    output logic [3:0]      req_file_active,
    output logic [dw-1:0]   req_file_read_data,
    output logic [7:0]      file_num,
    output logic            file_read,
    output logic            file_write,
    output logic [dw-1:0]   file_write_data,
    input  logic            file_active,
    input  logic [dw-1:0]   file_read_data,
    input  logic            err_clr,
    output logic [3:0]      grant,
    output logic [31:0]     arb_status
);

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_REQ     = 2'd1;
    localparam logic [1:0] ARB_ACTIVE  = 2'd2;
    localparam logic [1:0] ARB_RELEASE = 2'd3;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  rr_ptr;
    logic [1:0]  gnt_id;
    logic [1:0]  winner;
    logic [15:0] watchdog;
    logic        to_err;
    logic [1:0]  to_id;
    logic        coll_err;
    logic [1:0]  coll_id;
    logic [3:0]  req;
    logic        g_rd;
    logic        g_wr;
    logic        in_req;
    logic        collision;
    logic        timeout_hit;

    assign req = req_file_read | req_file_write;

    // Scan downward so the request closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        winner = rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[rr_ptr + 2'(k)]) begin
                winner = rr_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        file_num        = '0;
        file_write_data = '0;
        g_rd            = 1'b0;
        g_wr            = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) begin
                file_num        = req_file_num[8*i +: 8];
                file_write_data = req_file_write_data[dw*i +: dw];
                g_rd            = req_file_read[i];
                g_wr            = req_file_write[i];
            end
        end
    end

    assign in_req      = (state == ARB_REQ);
    assign collision   = in_req & g_rd & g_wr;
    assign file_write  = in_req & g_wr;
    assign file_read   = in_req & g_rd & ~g_wr;
    assign timeout_hit = ((state == ARB_REQ) || (state == ARB_ACTIVE)) && (watchdog == WD_LAST);

    assign req_file_active    = {4{file_active}} & grant;
    assign req_file_read_data = file_read_data;
    assign arb_status = {21'd0, coll_id, coll_err, to_id, to_err, (state != ARB_IDLE), grant};

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= ARB_IDLE;
            grant    <= 4'd0;
            gnt_id   <= 2'd0;
            rr_ptr   <= 2'd0;
            watchdog <= 16'd0;
            to_err   <= 1'b0;
            to_id    <= 2'd0;
            coll_err <= 1'b0;
            coll_id  <= 2'd0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        grant    <= 4'b0001 << winner;
                        gnt_id   <= winner;
                        watchdog <= 16'd0;
                        state    <= ARB_REQ;
                    end
                end
                ARB_REQ: begin
                    watchdog <= watchdog + 16'd1;
                    if (timeout_hit) begin
                        state <= ARB_RELEASE;
                    end else if (file_active) begin
                        state <= ARB_ACTIVE;
                    end
                end
                ARB_ACTIVE: begin
                    watchdog <= watchdog + 16'd1;
                    if (timeout_hit || !file_active) begin
                        state <= ARB_RELEASE;
                    end
                end
                ARB_RELEASE: begin
                    // Dead cycle lets the engine observe file_active low before the next grant.
                    grant  <= 4'd0;
                    rr_ptr <= gnt_id + 2'd1;
                    state  <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase

            // A fresh error outranks a simultaneous clear.
            if (timeout_hit) begin
                to_err <= 1'b1;
                to_id  <= gnt_id;
            end else if (err_clr) begin
                to_err <= 1'b0;
                to_id  <= 2'd0;
            end

            if (collision) begin
                coll_err <= 1'b1;
                coll_id  <= gnt_id;
            end else if (err_clr) begin
                coll_err <= 1'b0;
                coll_id  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_dsp_file_arbiter.sv
// tb/tb_dsp_file_arbiter.sv - self-checking bench for dsp_file_arbiter
module tb_dsp_file_arbiter;

    localparam int DW = 32;
    localparam int TO = 8;

    logic            wb_clk = 1'b0;
    logic            wb_rst_n = 1'b0;
    logic [3:0]      rd;
    logic [3:0]      wr;
    logic [7:0]      fn [4];
    logic [DW-1:0]   wd [4];
    logic            file_active;
    logic            err_clr;
    logic [DW-1:0]   file_read_data;
    logic [31:0]     req_file_num;
    logic [4*DW-1:0] req_file_write_data;
    logic [3:0]      req_file_active;
    logic [DW-1:0]   req_file_read_data;
    logic [7:0]      file_num;
    logic            file_read;
    logic            file_write;
    logic [DW-1:0]   file_write_data;
    logic [3:0]      grant;
    logic [31:0]     arb_status;

    int n_tests = 0;
    int n_fail  = 0;

    assign req_file_num        = {fn[3], fn[2], fn[1], fn[0]};
    assign req_file_write_data = {wd[3], wd[2], wd[1], wd[0]};

    dsp_file_arbiter #(.dw(DW), .TIMEOUT(TO)) dut (
        .wb_clk              (wb_clk),
        .wb_rst_n            (wb_rst_n),
        .req_file_num        (req_file_num),
        .req_file_read       (rd),
        .req_file_write      (wr),
        .req_file_write_data (req_file_write_data),
        .req_file_active     (req_file_active),
        .req_file_read_data  (req_file_read_data),
        .file_num            (file_num),
        .file_read           (file_read),
        .file_write          (file_write),
        .file_write_data     (file_write_data),
        .file_active         (file_active),
        .file_read_data      (file_read_data),
        .err_clr             (err_clr),
        .grant               (grant),
        .arb_status          (arb_status)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    task automatic do_reset();
        wb_rst_n       = 1'b0;
        rd             = 4'd0;
        wr             = 4'd0;
        file_active    = 1'b0;
        err_clr        = 1'b0;
        file_read_data = '0;
        for (int i = 0; i < 4; i++) begin
            fn[i] = 8'd0;
            wd[i] = '0;
        end
        tick();
        check("rst_grant", grant, 0);
        check("rst_status", arb_status, 0);
        check("rst_strobes", {file_read, file_write}, 0);
        check("rst_active", req_file_active, 0);
        tick();
        wb_rst_n = 1'b1;
    endtask

    // Granted engine e completes a transaction with file_active high for n edges.
    task automatic serve(input int e, input int n);
        file_active = 1'b1;
        tick();
        rd[e] = 1'b0;
        wr[e] = 1'b0;
        repeat (n - 1) tick();
        file_active = 1'b0;
        tick();
        tick();
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    function automatic int onehot_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) return i;
        end
        return 0;
    endfunction

    logic [3:0] mg;
    logic       seen;
    logic       endq;
    logic       inreq;
    int         mptr;
    int         win;
    int         gi;
    logic       fs_pend;
    int         fs_len;

    initial begin
        // Single engine read with three cycles of file_active
        do_reset();
        fn[2] = 8'h05;
        rd[2] = 1'b1;
        tick();
        check("t1_grant", grant, 4'b0100);
        check("t1_num", file_num, 8'h05);
        check("t1_read", file_read, 1);
        check("t1_busy", arb_status[4], 1);
        file_active = 1'b1;
        #1;
        check("t1_act", req_file_active, 4'b0100);
        tick();
        check("t1_read_gated", file_read, 0);
        rd[2] = 1'b0;
        tick();
        tick();
        file_active = 1'b0;
        tick();
        check("t1_dead_grant", grant, 4'b0100);
        check("t1_dead_act", req_file_active, 0);
        tick();
        check("t1_released", grant, 0);
        check("t1_idle", arb_status[4], 0);
        rd[0] = 1'b1;
        rd[3] = 1'b1;
        tick();
        check("t1_rr_ptr3", grant, 4'b1000);
        serve(3, 2);
        tick();
        check("t1_then0", grant, 4'b0001);
        serve(0, 2);

        // All four from reset
        do_reset();
        for (int i = 0; i < 4; i++) fn[i] = 8'(i * 17 + 1);
        rd = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_order", grant, 32'(1 << i));
            check("t2_num", file_num, 32'(i * 17 + 1));
            serve(i, 2);
            check("t2_gap", grant, 0);
        end

        // Immediate re-request yields to a pending engine
        do_reset();
        rd[0] = 1'b1;
        tick();
        check("t3_first", grant, 4'b0001);
        rd[1] = 1'b1;
        serve(0, 2);
        rd[0] = 1'b1;
        tick();
        check("t3_fair", grant, 4'b0010);
        serve(1, 2);
        tick();
        check("t3_eng0_after", grant, 4'b0001);
        serve(0, 2);

        // Watchdog abort
        do_reset();
        fn[1] = 8'h21;
        wr[1] = 1'b1;
        tick();
        check("t4_grant", grant, 4'b0010);
        check("t4_wr", file_write, 1);
        repeat (7) tick();
        check("t4_wr_hold", file_write, 1);
        check("t4_no_err_yet", arb_status[5], 0);
        tick();
        check("t4_wr_drop", file_write, 0);
        check("t4_status", arb_status[7:5], 3'b011);
        wr[1] = 1'b0;
        tick();
        check("t4_grant_clr", grant, 0);
        file_active = 1'b1;
        #1;
        check("t4_late_active", req_file_active, 0);
        tick();
        check("t4_late_grant", grant, 0);
        file_active = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_clr", arb_status[10:5], 0);

        // Read/write collision
        do_reset();
        rd[3] = 1'b1;
        wr[3] = 1'b1;
        wd[3] = 32'hDEADBEEF;
        tick();
        check("t5_grant", grant, 4'b1000);
        check("t5_wr", file_write, 1);
        check("t5_rd", file_read, 0);
        check("t5_wdata", file_write_data, 32'hDEADBEEF);
        tick();
        check("t5_coll", arb_status[10:8], 3'b111);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_err_wins", arb_status[8], 1);
        serve(3, 2);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr", arb_status[10:8], 0);

        // Reset mid-transaction
        do_reset();
        rd[0] = 1'b1;
        tick();
        serve(0, 2);
        fn[2] = 8'h33;
        rd[2] = 1'b1;
        tick();
        check("t6_grant", grant, 4'b0100);
        file_active = 1'b1;
        tick();
        check("t6_act", req_file_active, 4'b0100);
        #2;
        wb_rst_n = 1'b0;
        #1;
        check("t6_async_grant", grant, 0);
        check("t6_async_num", file_num, 0);
        check("t6_async_status", arb_status, 0);
        check("t6_async_act", req_file_active, 0);
        check("t6_async_strb", {file_read, file_write}, 0);
        file_active = 1'b0;
        rd = 4'b1001;
        tick();
        wb_rst_n = 1'b1;
        tick();
        check("t6_ptr0", grant, 4'b0001);
        serve(0, 2);
        tick();
        check("t6_then3", grant, 4'b1000);
        serve(3, 2);

        // Randomized traffic against a transaction-level model
        do_reset();
        mg = 4'd0; seen = 1'b0; endq = 1'b0; mptr = 0;
        fs_pend = 1'b0; fs_len = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            if (mg == 4'd0) begin
                if ((rd | wr) != 4'd0) begin
                    win  = pick(rd | wr, mptr);
                    mg   = 4'(1 << win);
                    mptr = (win + 1) % 4;
                    seen = 1'b0;
                    endq = 1'b0;
                end
            end else if (endq) begin
                mg = 4'd0;
            end else if (seen && !file_active) begin
                endq = 1'b1;
            end else if (file_active) begin
                seen = 1'b1;
            end
            gi    = onehot_idx(mg);
            inreq = (mg != 4'd0) && !seen && !endq;
            check("rnd_grant", grant, mg);
            check("rnd_busy", arb_status[4], mg != 4'd0);
            check("rnd_num", file_num, (mg != 4'd0) ? fn[gi] : 8'd0);
            check("rnd_wdata", file_write_data, (mg != 4'd0) ? wd[gi] : 32'd0);
            check("rnd_rd", file_read, inreq & rd[gi] & ~wr[gi]);
            check("rnd_wr", file_write, inreq & wr[gi]);
            check("rnd_act", req_file_active, file_active ? mg : 4'd0);
            check("rnd_rdata", req_file_read_data, file_read_data);
            check("rnd_err", arb_status[31:5], 0);

            for (int i = 0; i < 4; i++) begin
                if (rd[i] | wr[i]) begin
                    if (req_file_active[i]) begin
                        rd[i] = 1'b0;
                        wr[i] = 1'b0;
                    end
                end else if (!req_file_active[i] && $urandom_range(0, 3) == 0) begin
                    fn[i] = 8'($urandom);
                    wd[i] = $urandom;
                    if ($urandom_range(0, 1) == 1) rd[i] = 1'b1;
                    else wr[i] = 1'b1;
                end
            end
            if (file_active) begin
                fs_len--;
                if (fs_len == 0) file_active = 1'b0;
            end else if (fs_pend) begin
                fs_pend     = 1'b0;
                file_active = 1'b1;
            end else if (file_read | file_write) begin
                fs_len = $urandom_range(1, 3);
                if ($urandom_range(0, 1) == 1) fs_pend = 1'b1;
                else file_active = 1'b1;
            end
            file_read_data = $urandom;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_file_arbiter.md
Name: dsp_file_arbiter

Overview:
- Round-robin arbiter that shares the single DSP file-store port between four DSP equation engines.
- Each engine keeps its own file handshake (file_num, file_read/file_write strobe, file_write_data; file_active, file_read_data back).
- The arbiter grants one engine at a time, holds the grant for one complete file transaction, and routes file_active back only to the granted engine.
- A transaction watchdog and a sticky status word are readable through the DSP slave registers.

Parameters:
- dw, 32, file data width.
- TIMEOUT, 1024, maximum cycles from grant to end of transaction before the watchdog aborts it. Legal range 2..65535.

Ports:
- wb_clk  input  1  system clock.
- wb_rst_n  input  1  asynchronous active-low reset.
- req_file_num  input  32  {eng3,eng2,eng1,eng0} file numbers, 8 bits each.
- req_file_read  input  4  per-engine read strobe.
- req_file_write  input  4  per-engine write strobe.
- req_file_write_data  input  4*dw  per-engine write data, engine 0 in LSBs.
- req_file_active  output  4  per-engine file_active; only the granted bit can be 1.
- req_file_read_data  output  dw  shared read data, broadcast to all engines.
- file_num  output  8  to file store.
- file_read  output  1  to file store.
- file_write  output  1  to file store.
- file_write_data  output  dw  to file store.
- file_active  input  1  from file store.
- file_read_data  input  dw  from file store.
- err_clr  input  1  single-cycle pulse; clears sticky error fields.
- grant  output  4  one-hot current grant, registered.
- arb_status  output  32  [3:0] grant, [4] busy, [5] timeout_err sticky, [7:6] timeout engine id, [8] collision_err sticky, [10:9] collision engine id, [31:11] 0.

Behaviour:
- Reset (async assert, sync deassert): all outputs 0 and grant=0; state ARB_IDLE; rr_ptr=0; watchdog=0. Asserting reset mid-transaction drops file_read/file_write immediately.
- Request vector: req[i] = req_file_read[i] | req_file_write[i].
- ARB_IDLE:
  - If any req is set, search from rr_ptr upward modulo 4; the first set bit wins.
  - Next cycle: grant<=onehot(winner), state<=ARB_REQ, watchdog<=0.
  - Latency: strobe at cycle N, grant at N+1, shared strobe visible at N+1.
- Shared outputs are combinational from the registered grant:
  - file_num and file_write_data are muxed from the granted engine; 0 when grant=0.
  - file_read = granted read strobe & (state==ARB_REQ).
  - file_write = granted write strobe & (state==ARB_REQ).
  - req_file_active[i] = file_active & grant[i].
  - req_file_read_data = file_read_data, ungated.
- ARB_REQ:
  - file_active=1: go ARB_ACTIVE.
  - The engine drops its strobe after seeing file_active; the arbiter does not require this.
- ARB_ACTIVE:
  - Hold grant while file_active=1.
  - file_active=0: go ARB_RELEASE.
- ARB_RELEASE: one dead cycle.
  - grant<=0, rr_ptr<=winner+1 (mod 4), state<=ARB_IDLE.
  - This guarantees the engine sees file_active low before any other engine is granted.
- Collision: granted engine has read and write both high in ARB_REQ.
  - Forward write only (file_read forced 0).
  - Set collision_err and record the engine id.
- Watchdog:
  - Increments every cycle in ARB_REQ and ARB_ACTIVE.
  - At watchdog==TIMEOUT-1 with the transaction not yet released: set timeout_err, record the engine id, go ARB_RELEASE (strobes drop that cycle).
  - A late file_active after an abort is ignored, since grant=0.
- Sticky errors:
  - err_clr clears both error flags and their ids.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag=1).
- busy = state!=ARB_IDLE.
- Fairness: an engine that re-requests immediately is served only after every other pending engine. Worst-case wait is 3 transactions.
- Strobes that fall before grant are dropped silently, with no error.

Test Plan:
- Single engine: eng2 read, file_num=8'h05; file store asserts active 3 cycles -> grant=4'b0100 at N+1, file_num=5, file_read=1 until active, req_file_active[2] pulses, other bits 0; grant=0 after one dead cycle; rr_ptr=3.
- All four request together from reset -> grants in order 0,1,2,3, each one-hot, never overlapping, with ≥1 idle cycle of grant=0 between them.
- Eng0 re-requests right after its release while eng1 is pending -> eng1 is granted before eng0.
- Timeout: TIMEOUT=8, eng1 write, file_active held 0 -> file_write drops after 8 cycles in ARB_REQ; arb_status[5]=1, [7:6]=1; err_clr -> arb_status[7:5]=0.
- Collision: eng3 with read=write=1, data 32'hDEADBEEF -> file_write=1, file_read=0, file_write_data=32'hDEADBEEF, arb_status[8]=1, [10:9]=3.
- Reset mid-transaction: wb_rst_n low while in ARB_ACTIVE -> all outputs 0 immediately (asynchronous, no clock edge needed); after release, the next request is served from rr_ptr=0.
